// File: rtl/oled_spi_write.sv
// Write-only SPI master for an SSD13xx-style OLED panel: one byte per request, MSB first, SCLK idles high.
// Define OLED_SPI_BUSY_EN to add a BUSY output that covers the whole transfer including the DONE cycle.
module oled_spi_write #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       WRITE_START,
  input  logic [7:0] DATA,
  input  logic       DC_IN,
  output logic       WRITE_DONE,
  output logic       OLED_CS,
  output logic       OLED_DC,
  output logic       OLED_SCLK,
`ifdef OLED_SPI_BUSY_EN
  output logic       OLED_SDIN,
  output logic       BUSY
`else
  output logic       OLED_SDIN
`endif
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    DONE,
    RELEASE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_div;
  logic [7:0]  w_div_next;
  logic [2:0]  r_bit;
  logic [7:0]  r_data;
  logic        r_dc;
  logic        w_phase_end;
  logic        w_accept;

  assign w_phase_end = (r_div == DIV_LAST);
  assign w_accept    = (r_state == IDLE) && WRITE_START;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (WRITE_START) w_next = SHIFT_LO;
      SHIFT_LO: if (w_phase_end) w_next = SHIFT_HI;
      SHIFT_HI: if (w_phase_end) w_next = (r_bit == 3'd0) ? DONE : SHIFT_LO;
      DONE:     w_next = RELEASE;
      RELEASE:  if (!WRITE_START) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Half-period counter restarts at every phase boundary and only runs while shifting.
  always_comb begin
    w_div_next = '0;
    if ((w_next == r_state) && ((r_state == SHIFT_LO) || (r_state == SHIFT_HI)))
      w_div_next = r_div + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_dc    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_div   <= w_div_next;
      if (w_accept) begin
        r_data <= DATA;
        r_dc   <= DC_IN;
        r_bit  <= 3'd7;
      end else if ((r_state == SHIFT_HI) && w_phase_end) begin
        r_bit <= r_bit - 3'd1;
      end
    end
  end

  // Outputs decode the registered state only, so they change exactly on CLK edges.
  always_comb begin
    WRITE_DONE = 1'b0;
    OLED_CS    = 1'b1;
    OLED_DC    = 1'b0;
    OLED_SCLK  = 1'b1;
    OLED_SDIN  = 1'b0;
    unique case (r_state)
      SHIFT_LO: begin
        OLED_CS   = 1'b0;
        OLED_DC   = r_dc;
        OLED_SCLK = 1'b0;
        OLED_SDIN = r_data[r_bit];
      end
      SHIFT_HI: begin
        OLED_CS   = 1'b0;
        OLED_DC   = r_dc;
        OLED_SDIN = r_data[r_bit];
      end
      DONE:     WRITE_DONE = 1'b1;
      default:  ;
    endcase
  end

`ifdef OLED_SPI_BUSY_EN
  assign BUSY = (r_state == SHIFT_LO) || (r_state == SHIFT_HI) || (r_state == DONE);
`endif

endmodule

// File: tb/tb_oled_spi_write.sv
// Scoreboard bench for oled_spi_write: two instances (CLK_DIV=2 and CLK_DIV=1) driven in turn,
// every output compared each cycle against a timing model derived from the acceptance cycle.
module tb_oled_spi_write;

  typedef struct {
    int         g;
    int         a;
    logic [7:0] d;
    logic       dc;
    int         abort;
  } exp_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  bit         chk_en = 1'b0;
  exp_t       sb[$];

  logic       rst_n [2];
  logic       start_i [2];
  logic [7:0] data_i [2];
  logic       dc_i [2];
  logic       done_o [2];
  logic       cs_o [2];
  logic       dc_o [2];
  logic       sclk_o [2];
  logic       sdin_o [2];
  logic       busy_o [2];
  logic       rst_low [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) for (int i = 0; i < 2; i++) rst_low[i] <= !rst_n[i];

  task automatic chk(input string nm, input int g, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h expected=%h", nm, g, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int K = (g == 0) ? 2 : 1;

    oled_spi_write #(.CLK_DIV(K)) u_dut (
      .CLK         (clk),
      .RST_N       (rst_n[g]),
      .WRITE_START (start_i[g]),
      .DATA        (data_i[g]),
      .DC_IN       (dc_i[g]),
      .WRITE_DONE  (done_o[g]),
      .OLED_CS     (cs_o[g]),
      .OLED_DC     (dc_o[g]),
      .OLED_SCLK   (sclk_o[g]),
`ifdef OLED_SPI_BUSY_EN
      .OLED_SDIN   (sdin_o[g]),
      .BUSY        (busy_o[g])
`else
      .OLED_SDIN   (sdin_o[g])
`endif
    );

`ifndef OLED_SPI_BUSY_EN
    assign busy_o[g] = 1'b0;
`endif

    exp_t       f;
    bit         act, in_win, dexp;
    int         rel;
    logic       prev_sclk = 1'b1;
    logic [7:0] acc = '0;
    int         nrise = 0;

    always @(negedge clk) begin
      if (chk_en) begin
        act = (sb.size() > 0) && (sb[0].g == g);
        if (act) f = sb[0];
        rel    = cyc - f.a - 1;
        in_win = act && (cyc >= f.a + 1) && (cyc <= ((f.abort >= 0) ? f.abort : f.a + 16 * K));
        dexp   = act && (f.abort < 0) && (cyc == f.a + 16 * K + 1);
        if (rst_low[g]) begin
          chk("rst_cs", g, 8'(cs_o[g]), 8'd1);
          chk("rst_sclk", g, 8'(sclk_o[g]), 8'd1);
          chk("rst_sdin", g, 8'(sdin_o[g]), 8'd0);
          chk("rst_dc", g, 8'(dc_o[g]), 8'd0);
          chk("rst_done", g, 8'(done_o[g]), 8'd0);
`ifdef OLED_SPI_BUSY_EN
          chk("rst_busy", g, 8'(busy_o[g]), 8'd0);
`endif
        end else begin
          chk("cs", g, 8'(cs_o[g]), 8'(!in_win));
          chk("sclk", g, 8'(sclk_o[g]), in_win ? 8'((rel / K) % 2) : 8'd1);
          chk("sdin", g, 8'(sdin_o[g]), in_win ? 8'(f.d[7 - rel / (2 * K)]) : 8'd0);
          chk("done", g, 8'(done_o[g]), 8'(dexp));
          if (in_win) chk("dc", g, 8'(dc_o[g]), 8'(f.dc));
`ifdef OLED_SPI_BUSY_EN
          chk("busy", g, 8'(busy_o[g]), 8'(in_win || dexp));
`endif
        end
        if (!cs_o[g] && sclk_o[g] && !prev_sclk) begin
          acc = {acc[6:0], sdin_o[g]};
          nrise++;
        end
        prev_sclk = sclk_o[g];
        if (done_o[g] && dexp) begin
          chk("byte", g, acc, f.d);
          chk("nrise", g, 8'(nrise), 8'd8);
        end
        if (act && (dexp || ((f.abort >= 0) && (cyc == f.abort + 1)))) begin
          void'(sb.pop_front());
          acc   = '0;
          nrise = 0;
        end
      end
    end
  end

  // Raises the request in the current cycle; returns at the earliest cycle a new request may start.
  task automatic send(input int g, input logic [7:0] d, input logic dcv, input int hold,
                      input int drop_at, input int scr_mode, input int gap);
    int   k, a, dn, nxt;
    exp_t e;
    k = (g == 0) ? 2 : 1;
    a = cyc;
    start_i[g] = 1'b1;
    data_i[g]  = d;
    dc_i[g]    = dcv;
    e.g = g; e.a = a; e.d = d; e.dc = dcv; e.abort = -1;
    sb.push_back(e);
    dn = a + 16 * k + 1;
    while (cyc < dn + hold) begin
      step();
      if (scr_mode == 1) begin
        data_i[g] = 8'($urandom);
        dc_i[g]   = 1'($urandom);
      end
      if ((scr_mode == 2) && (cyc == a + 3)) data_i[g] = 8'hFF;
      if ((drop_at > 0) && (cyc == a + drop_at)) start_i[g] = 1'b0;
    end
    start_i[g] = 1'b0;
    nxt = (hold == 0) ? dn + 2 : dn + hold + 1;
    while (cyc < nxt + gap) step();
  endtask

  task automatic abort_then_send(input int g, input logic [7:0] d);
    int   a;
    exp_t e;
    a = cyc;
    start_i[g] = 1'b1;
    data_i[g]  = d;
    dc_i[g]    = 1'b1;
    e.g = g; e.a = a; e.d = d; e.dc = 1'b1; e.abort = -1;
    sb.push_back(e);
    while (cyc < a + 10) step();
    rst_n[g] = 1'b0;
    e = sb[0];
    e.abort = a + 10;
    sb[0] = e;
    step();
    rst_n[g] = 1'b1;
    send(g, ~d, 1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; start_i[i] = 1'b0; data_i[i] = '0; dc_i[i] = 1'b0;
    end
    step();
    chk_en = 1'b1;
    step(); step();

    // CLK_DIV=2 instance; request raised on the first cycle out of reset.
    rst_n[0] = 1'b1;
    send(0, 8'hAE, 1'b0, 0, 0, 0, 1);
    send(0, 8'h00, 1'b0, 0, 0, 2, 0);
    send(0, 8'($urandom), 1'b1, 5, 0, 0, 2);
    abort_then_send(0, 8'hC3);
    for (int n = 0; n < 8; n++)
      send(0, 8'($urandom), 1'($urandom), int'($urandom_range(0, 5)),
           ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 32)) : 0, 1,
           int'($urandom_range(0, 2)));

    // CLK_DIV=1 instance.
    rst_n[1] = 1'b1;
    send(1, 8'h81, 1'b1, 0, 0, 0, 0);
    send(1, 8'($urandom), 1'b0, 5, 0, 0, 1);
    abort_then_send(1, 8'h5A);
    for (int n = 0; n < 8; n++)
      send(1, 8'($urandom), 1'($urandom), int'($urandom_range(0, 5)),
           ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16)) : 0, 1,
           int'($urandom_range(0, 2)));

    repeat (4) step();
    chk("sb_empty", 0, 8'(sb.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oled_spi_write.md
OLED_SPI_WRITE -- requirements
Module: oled_spi_write

Interface
REQ-001 SHALL: parameter CLK_DIV, default 4, is the SCLK half-period in CLK cycles (legal range 1..255).
REQ-002 SHALL: CLK  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL: RST_N  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL: WRITE_START  input  1  byte request; held high by the requester until it sees WRITE_DONE.
REQ-005 SHALL: DATA  input  8  byte to send; sampled only on acceptance.
REQ-006 SHALL: DC_IN  input  1  0 = command byte, 1 = display data byte; sampled only on acceptance.
REQ-007 SHALL: WRITE_DONE  output  1  one-cycle pulse after the byte is fully shifted out.
REQ-008 SHALL: OLED_CS  output  1  active-low panel chip select.
REQ-009 SHALL: OLED_DC  output  1  panel data/command line.
REQ-010 SHALL: OLED_SCLK  output  1  serial clock; idles high.
REQ-011 SHALL: OLED_SDIN  output  1  serial data, MSB first.

Function
REQ-012 SHALL: FSM states are IDLE, SHIFT_LO, SHIFT_HI, DONE, RELEASE.
REQ-013 SHALL: IDLE with WRITE_START=1 in cycle 0 latches DATA and DC_IN; enters SHIFT_LO for bit 7.
REQ-014 SHALL: from cycle 1 through the last SHIFT_HI cycle, OLED_CS=0 and OLED_DC=latched DC_IN.
REQ-015 SHALL: SHIFT_LO lasts CLK_DIV cycles with OLED_SCLK=0 and OLED_SDIN=current bit; it then goes to SHIFT_HI.
REQ-016 SHALL: SHIFT_HI lasts CLK_DIV cycles with OLED_SCLK=1 and OLED_SDIN held; the panel samples on the rising edge.
REQ-017 SHALL: a 3-bit bit counter decrements after each SHIFT_HI. After bit 0, SHIFT_HI goes to DONE; otherwise it goes to SHIFT_LO.
REQ-018 SHALL: the half-period counter is 8 bits wide and reloads to 0 on every phase entry.
REQ-019 SHALL: in DONE (cycle 16*CLK_DIV+1), WRITE_DONE=1 for exactly one cycle, OLED_CS=1 and OLED_SCLK=1.
REQ-020 SHALL: RELEASE waits until WRITE_START=0, then enters IDLE. A request still high after DONE is never retransmitted.
REQ-021 SHALL: a new byte is accepted no earlier than the first IDLE cycle with WRITE_START=1.
REQ-022 SHALL: changes on DATA or DC_IN during a transfer have no effect on the byte being sent.
REQ-023 SHALL: WRITE_START dropping mid-transfer does not abort; the byte completes and WRITE_DONE still pulses.
REQ-024 SHALL: OLED_SDIN is 0 whenever OLED_CS=1.

Reset
REQ-025 SHALL: while RST_N=0 at a rising CLK edge, the state goes to IDLE, both counters clear, WRITE_DONE=0, OLED_CS=1, OLED_SCLK=1, OLED_SDIN=0, OLED_DC=0.
REQ-026 SHALL: reset during any transfer aborts it at that edge, with no WRITE_DONE and CS deasserted.
REQ-027 SHALL: WRITE_START=1 on the first cycle with RST_N=1 is accepted in that cycle.

Configuration
REQ-028 SHALL: with OLED_SPI_BUSY_EN defined, an extra output port BUSY (1 bit) is 1 from cycle 1 through the DONE cycle inclusive, and 0 otherwise and in reset.
REQ-029 SHALL: without OLED_SPI_BUSY_EN, there is no BUSY port and all other behaviour is identical.

Verification
REQ-030 SHALL: with CLK_DIV=2, DC_IN=0, DATA=0xAE and WRITE_START held until done, the bench SHALL see SDIN 1,0,1,0,1,1,1,0 at the 8 SCLK rises, DC=0, CS=0 in cycles 1..32, and WRITE_DONE only in cycle 33.
REQ-031 SHALL: with CLK_DIV=1, DC_IN=1 and DATA=0x81, the bench SHALL see bits 1,0,0,0,0,0,0,1, DC=1, and WRITE_DONE in cycle 17.
REQ-032 SHALL: if WRITE_START is held high 5 cycles past WRITE_DONE, the bench SHALL see exactly one byte sent and CS stay high until WRITE_START falls and rises again.
REQ-033 SHALL: if DATA changes from 0x00 to 0xFF at cycle 3 of a 0x00 transfer, the bench SHALL see all 8 sampled bits as 0.
REQ-034 SHALL: if RST_N=0 for one edge at cycle 10 of a CLK_DIV=2 transfer, the bench SHALL see CS=1 and SCLK=1 next cycle, no WRITE_DONE, and the next request sent in full.
REQ-035 SHALL: with OLED_SPI_BUSY_EN and CLK_DIV=2, the bench SHALL see BUSY high in cycles 1..33 and low in cycle 34.
